// File: rtl/vga_timing_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vga_timing_pkg
// Description : Raster timing descriptor, common presets and total helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package vga_timing_pkg;

    typedef struct packed {
        logic [15:0] h_active;
        logic [15:0] h_fp;
        logic [15:0] h_sync;
        logic [15:0] h_bp;
        logic [15:0] v_active;
        logic [15:0] v_fp;
        logic [15:0] v_sync;
        logic [15:0] v_bp;
    } timing_t;

    localparam timing_t VGA_640x480 = '{
        h_active: 16'd640, h_fp: 16'd16, h_sync: 16'd96,  h_bp: 16'd48,
        v_active: 16'd480, v_fp: 16'd10, v_sync: 16'd2,   v_bp: 16'd33
    };

    localparam timing_t SVGA_800x600 = '{
        h_active: 16'd800, h_fp: 16'd40, h_sync: 16'd128, h_bp: 16'd88,
        v_active: 16'd600, v_fp: 16'd1,  v_sync: 16'd4,   v_bp: 16'd23
    };

    function automatic int h_total(input timing_t t);
        return int'(t.h_active) + int'(t.h_fp) + int'(t.h_sync) + int'(t.h_bp);
    endfunction

    function automatic int v_total(input timing_t t);
        return int'(t.v_active) + int'(t.v_fp) + int'(t.v_sync) + int'(t.v_bp);
    endfunction

endpackage
`default_nettype wire

// File: rtl/vga_timing_gen_pixel_strobe_div.sv
`default_nettype none
// ============================================================================
// Module      : pixel_strobe_div
// Description : Divides the pixel clock into a one-cycle pixel tick, gated by en.
// Revision    : 1.0 - initial release
// ============================================================================
module pixel_strobe_div #(
    parameter int CLK_DIV = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    output logic tick
);

    // With CLK_DIV=1 the counter degenerates to a constant zero and tick = en.
    localparam int                c_DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [c_DIV_W-1:0] c_DIV_LAST = c_DIV_W'(CLK_DIV - 1);

    logic [c_DIV_W-1:0] r_div;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_div <= '0;
        end else if (en) begin
            r_div <= (r_div == c_DIV_LAST) ? '0 : r_div + 1'b1;
        end
    end

    assign tick = en & (r_div == c_DIV_LAST);

endmodule
`default_nettype wire

// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module      : vga_timing_gen
// Description : Parametrised VGA/HDMI raster timing generator with pixel strobe.
// Revision    : 1.0 - initial release
// ============================================================================
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int H_ACTIVE    = 640,
    parameter int H_FP        = 16,
    parameter int H_SYNC      = 96,
    parameter int H_BP        = 48,
    parameter int V_ACTIVE    = 480,
    parameter int V_FP        = 10,
    parameter int V_SYNC      = 2,
    parameter int V_BP        = 33,
    parameter bit SYNC_POL    = 1'b0,
    parameter int CLK_DIV     = 1,
    parameter int COORD_W     = 10,
    parameter int FRAME_CNT_W = 16
) (
    input  logic                   pixel_clk,
    input  logic                   reset,
    input  logic                   en,
    output logic                   hs,
    output logic                   vs,
    output logic                   active_nblank,
    output logic                   sync,
    output logic [COORD_W-1:0]     drawX,
    output logic [COORD_W-1:0]     drawY,
    output logic                   pix_stb,
    output logic                   sof,
    output logic                   eol,
    output logic [FRAME_CNT_W-1:0] frame_count
);

    localparam timing_t c_TIMING = '{
        h_active: 16'(H_ACTIVE), h_fp: 16'(H_FP), h_sync: 16'(H_SYNC), h_bp: 16'(H_BP),
        v_active: 16'(V_ACTIVE), v_fp: 16'(V_FP), v_sync: 16'(V_SYNC), v_bp: 16'(V_BP)
    };
    localparam int c_H_TOTAL = h_total(c_TIMING);
    localparam int c_V_TOTAL = v_total(c_TIMING);

    generate
        if (H_ACTIVE < 1 || H_FP < 1 || H_SYNC < 1 || H_BP < 1 ||
            V_ACTIVE < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1) begin : g_bad_timing
            $error("vga_timing_gen: every timing parameter must be non-zero");
        end
        if (CLK_DIV < 1) begin : g_bad_div
            $error("vga_timing_gen: CLK_DIV must be at least 1");
        end
        if (c_H_TOTAL > 2**COORD_W || c_V_TOTAL > 2**COORD_W) begin : g_bad_width
            $error("vga_timing_gen: COORD_W too narrow for the raster totals");
        end
    endgenerate

    localparam logic [COORD_W-1:0] c_H_LAST     = COORD_W'(c_H_TOTAL - 1);
    localparam logic [COORD_W-1:0] c_V_LAST     = COORD_W'(c_V_TOTAL - 1);
    localparam logic [COORD_W-1:0] c_H_ACT      = COORD_W'(H_ACTIVE);
    localparam logic [COORD_W-1:0] c_V_ACT      = COORD_W'(V_ACTIVE);
    localparam logic [COORD_W-1:0] c_HS_FIRST   = COORD_W'(H_ACTIVE + H_FP);
    localparam logic [COORD_W-1:0] c_HS_LAST    = COORD_W'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [COORD_W-1:0] c_VS_FIRST   = COORD_W'(V_ACTIVE + V_FP);
    localparam logic [COORD_W-1:0] c_VS_LAST    = COORD_W'(V_ACTIVE + V_FP + V_SYNC - 1);

    logic               w_tick;
    logic               r_first;
    logic [COORD_W-1:0] r_hcnt;
    logic [COORD_W-1:0] r_vcnt;
    logic [COORD_W-1:0] w_next_h;
    logic [COORD_W-1:0] w_next_v;
    logic               w_frame_wrap;
    logic               w_hs_on;
    logic               w_vs_on;

    pixel_strobe_div #(
        .CLK_DIV (CLK_DIV)
    ) u_div (
        .clk   (pixel_clk),
        .reset (reset),
        .en    (en),
        .tick  (w_tick)
    );

    // The first tick after reset presents (0,0) itself rather than advancing past it.
    always_comb begin
        w_next_h     = r_hcnt;
        w_next_v     = r_vcnt;
        w_frame_wrap = 1'b0;
        if (r_first) begin
            w_next_h = '0;
            w_next_v = '0;
        end else if (r_hcnt == c_H_LAST) begin
            w_next_h = '0;
            if (r_vcnt == c_V_LAST) begin
                w_next_v     = '0;
                w_frame_wrap = 1'b1;
            end else begin
                w_next_v = r_vcnt + 1'b1;
            end
        end else begin
            w_next_h = r_hcnt + 1'b1;
        end
    end

    assign w_hs_on = (w_next_h >= c_HS_FIRST) && (w_next_h <= c_HS_LAST);
    assign w_vs_on = (w_next_v >= c_VS_FIRST) && (w_next_v <= c_VS_LAST);

    always_ff @(posedge pixel_clk) begin
        if (!reset) begin
            r_first       <= 1'b1;
            r_hcnt        <= '0;
            r_vcnt        <= '0;
            frame_count   <= '0;
            hs            <= ~SYNC_POL;
            vs            <= ~SYNC_POL;
            sync          <= 1'b1;
            active_nblank <= 1'b0;
            pix_stb       <= 1'b0;
            sof           <= 1'b0;
            eol           <= 1'b0;
        end else begin
            pix_stb <= w_tick;
            sof     <= w_tick && (w_next_h == '0) && (w_next_v == '0);
            eol     <= w_tick && (w_next_h == '0);
            if (w_tick) begin
                r_first       <= 1'b0;
                r_hcnt        <= w_next_h;
                r_vcnt        <= w_next_v;
                hs            <= w_hs_on ? SYNC_POL : ~SYNC_POL;
                vs            <= w_vs_on ? SYNC_POL : ~SYNC_POL;
                sync          <= ~(w_hs_on | w_vs_on);
                active_nblank <= (w_next_h < c_H_ACT) && (w_next_v < c_V_ACT);
                if (w_frame_wrap) begin
                    frame_count <= frame_count + 1'b1;
                end
            end
        end
    end

    assign drawX = r_hcnt;
    assign drawY = r_vcnt;

endmodule
`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_vga_timing_gen
// Description : Scoreboard bench for vga_timing_gen on three raster configurations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_timing_gen;

    typedef struct {
        int ha, hf, hsw, hb, va, vf, vsw, vb, div, fcw;
        bit pol;
    } cfg_t;

    typedef struct {
        bit first;
        int div, x, y, fc;
        bit hs, vs, act, sync, stb, sof, eol;
    } mst_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [2:0]  rst_v = '0;
    logic [2:0]  en_v  = '0;
    cfg_t        cfg [3];
    mst_t        ms  [3];
    logic [54:0] sb  [$];
    logic [54:0] obs [3];
    int          total = 0;
    int          bad   = 0;

    // DUT 0: default 640x480
    logic       b_hs, b_vs, b_act, b_sync, b_stb, b_sof, b_eol;
    logic [9:0] b_x, b_y;
    logic [15:0] b_fc;
    // DUT 1: tiny raster, 2-bit frame counter
    logic       t_hs, t_vs, t_act, t_sync, t_stb, t_sof, t_eol;
    logic [3:0] t_x, t_y;
    logic [1:0] t_fc;
    // DUT 2: tiny raster, CLK_DIV=2, active-high syncs
    logic       a_hs, a_vs, a_act, a_sync, a_stb, a_sof, a_eol;
    logic [3:0] a_x, a_y;
    logic [15:0] a_fc;

    vga_timing_gen u_big (
        .pixel_clk(clk), .reset(rst_v[0]), .en(en_v[0]),
        .hs(b_hs), .vs(b_vs), .active_nblank(b_act), .sync(b_sync),
        .drawX(b_x), .drawY(b_y), .pix_stb(b_stb), .sof(b_sof), .eol(b_eol),
        .frame_count(b_fc)
    );

    vga_timing_gen #(
        .H_ACTIVE(4), .H_FP(1), .H_SYNC(1), .H_BP(1),
        .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .SYNC_POL(1'b0), .CLK_DIV(1), .COORD_W(4), .FRAME_CNT_W(2)
    ) u_tiny (
        .pixel_clk(clk), .reset(rst_v[1]), .en(en_v[1]),
        .hs(t_hs), .vs(t_vs), .active_nblank(t_act), .sync(t_sync),
        .drawX(t_x), .drawY(t_y), .pix_stb(t_stb), .sof(t_sof), .eol(t_eol),
        .frame_count(t_fc)
    );

    vga_timing_gen #(
        .H_ACTIVE(4), .H_FP(1), .H_SYNC(1), .H_BP(1),
        .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .SYNC_POL(1'b1), .CLK_DIV(2), .COORD_W(4), .FRAME_CNT_W(16)
    ) u_alt (
        .pixel_clk(clk), .reset(rst_v[2]), .en(en_v[2]),
        .hs(a_hs), .vs(a_vs), .active_nblank(a_act), .sync(a_sync),
        .drawX(a_x), .drawY(a_y), .pix_stb(a_stb), .sof(a_sof), .eol(a_eol),
        .frame_count(a_fc)
    );

    assign obs[0] = {16'(b_x), 16'(b_y), 16'(b_fc), b_hs, b_vs, b_act, b_sync, b_stb, b_sof, b_eol};
    assign obs[1] = {16'(t_x), 16'(t_y), 16'(t_fc), t_hs, t_vs, t_act, t_sync, t_stb, t_sof, t_eol};
    assign obs[2] = {16'(a_x), 16'(a_y), 16'(a_fc), a_hs, a_vs, a_act, a_sync, a_stb, a_sof, a_eol};

    function automatic bit in_rng(input int v, input int lo, input int n);
        return (v >= lo) && (v < lo + n);
    endfunction

    // Reference raster: state after one pixel_clk edge given the sampled inputs.
    function automatic mst_t model_step(input cfg_t c, input mst_t s, input bit rn, input bit e);
        mst_t n;
        bit   tick, hon, von;
        n = s;
        if (!rn) begin
            n.first = 1'b1; n.div = 0; n.x = 0; n.y = 0; n.fc = 0;
            n.hs = !c.pol; n.vs = !c.pol; n.act = 1'b0; n.sync = 1'b1;
            n.stb = 1'b0; n.sof = 1'b0; n.eol = 1'b0;
            return n;
        end
        tick = e && (s.div == c.div - 1);
        if (e) n.div = (s.div + 1) % c.div;
        n.stb = tick; n.sof = 1'b0; n.eol = 1'b0;
        if (tick) begin
            if (s.first) begin
                n.first = 1'b0;
            end else if (s.x == c.ha + c.hf + c.hsw + c.hb - 1) begin
                n.x = 0;
                if (s.y == c.va + c.vf + c.vsw + c.vb - 1) begin
                    n.y  = 0;
                    n.fc = (s.fc + 1) % (1 << c.fcw);
                end else begin
                    n.y = s.y + 1;
                end
            end else begin
                n.x = s.x + 1;
            end
            hon    = in_rng(n.x, c.ha + c.hf, c.hsw);
            von    = in_rng(n.y, c.va + c.vf, c.vsw);
            n.hs   = hon ? c.pol : !c.pol;
            n.vs   = von ? c.pol : !c.pol;
            n.act  = (n.x < c.ha) && (n.y < c.va);
            n.sync = !(hon || von);
            n.sof  = (n.x == 0) && (n.y == 0);
            n.eol  = (n.x == 0);
        end
        return n;
    endfunction

    function automatic logic [54:0] pack(input mst_t s);
        return {16'(s.x), 16'(s.y), 16'(s.fc), s.hs, s.vs, s.act, s.sync, s.stb, s.sof, s.eol};
    endfunction

    task automatic step(input int d, input bit r, input bit e);
        rst_v[d] = r;
        en_v[d]  = e;
        ms[d]    = model_step(cfg[d], ms[d], r, e);
        sb.push_back(pack(ms[d]));
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [54:0] want;
        for (int i = 0; i < 3; i++) begin
            step(0, 1'b0, 1'b1);
            want = sb.pop_front(); total++;
            if (obs[0] !== want) begin bad++; $display("FAIL reset cyc=%0d got=%h want=%h", i, obs[0], want); end
        end
        total++;
        if ({b_hs, b_vs, b_sync, b_act, b_stb, b_sof, b_eol} !== 7'b1110000) begin
            bad++; $display("FAIL reset_levels got=%b want=1110000", {b_hs, b_vs, b_sync, b_act, b_stb, b_sof, b_eol});
        end
    endtask

    task automatic test_first_line();
        logic [54:0] want;
        int hs_cnt = 0, hs_first = -1;
        for (int i = 0; i < 900; i++) begin
            step(0, 1'b1, 1'b1);
            want = sb.pop_front(); total++;
            if (obs[0] !== want) begin bad++; $display("FAIL line0 cyc=%0d got=%h want=%h", i, obs[0], want); end
            if (i == 0) begin
                total++;
                if ({b_stb, b_sof, b_eol, b_act, b_x, b_y} !== {4'b1111, 20'd0}) begin
                    bad++; $display("FAIL first_pixel got=%b want=%b", {b_stb, b_sof, b_eol, b_act, b_x, b_y}, {4'b1111, 20'd0});
                end
            end
            if (b_hs === 1'b0 && b_y == 10'd0) begin
                hs_cnt++;
                if (hs_first < 0) hs_first = int'(b_x);
            end
        end
        total++;
        if (hs_cnt != 96) begin bad++; $display("FAIL hs_width got=%0d want=96", hs_cnt); end
        total++;
        if (hs_first != 656) begin bad++; $display("FAIL hs_start got=%0d want=656", hs_first); end
    endtask

    task automatic test_pause();
        logic [54:0] want;
        int guard = 0;
        while (!(ms[0].x == 100 && ms[0].y == 7) && guard < 8000) begin
            step(0, 1'b1, 1'b1); guard++;
            want = sb.pop_front(); total++;
            if (obs[0] !== want) begin bad++; $display("FAIL pause_run cyc=%0d got=%h want=%h", guard, obs[0], want); end
        end
        total++;
        if (guard >= 8000) begin bad++; $display("FAIL pause_reach got=timeout want=(100,7)"); end
        for (int i = 0; i < 50; i++) begin
            step(0, 1'b1, 1'b0);
            want = sb.pop_front(); total++;
            if (obs[0] !== want || b_x !== 10'd100 || b_y !== 10'd7 || b_stb !== 1'b0) begin
                bad++; $display("FAIL pause_hold cyc=%0d got=%h want=%h", i, obs[0], want);
            end
        end
        step(0, 1'b1, 1'b1);
        want = sb.pop_front(); total++;
        if (obs[0] !== want || b_x !== 10'd101 || b_y !== 10'd7 || b_stb !== 1'b1) begin
            bad++; $display("FAIL pause_resume got x=%0d y=%0d stb=%b want x=101 y=7 stb=1", b_x, b_y, b_stb);
        end
    endtask

    task automatic test_reset_mid();
        logic [54:0] want;
        int guard = 0;
        while (ms[0].x != 400 && guard < 1000) begin
            step(0, 1'b1, 1'b1); guard++;
            want = sb.pop_front(); total++;
            if (obs[0] !== want) begin bad++; $display("FAIL mid_run cyc=%0d got=%h want=%h", guard, obs[0], want); end
        end
        step(0, 1'b0, 1'b1);
        want = sb.pop_front(); total++;
        if (obs[0] !== want || b_x !== 10'd0 || b_y !== 10'd0 || b_fc !== 16'd0 || b_act !== 1'b0) begin
            bad++; $display("FAIL mid_reset got=%h want=%h", obs[0], want);
        end
        step(0, 1'b1, 1'b1);
        want = sb.pop_front(); total++;
        if (obs[0] !== want || b_sof !== 1'b1) begin
            bad++; $display("FAIL mid_release got sof=%b obs=%h want sof=1 obs=%h", b_sof, obs[0], want);
        end
    endtask

    task automatic test_tiny_frames();
        logic [54:0] want;
        int fc_seq [4] = '{1, 2, 3, 0};
        int n_sof = 0, last_sof = -1, last_eol = -1;
        step(1, 1'b0, 1'b1); void'(sb.pop_front());
        step(1, 1'b0, 1'b1);
        want = sb.pop_front(); total++;
        if (obs[1] !== want) begin bad++; $display("FAIL tiny_reset got=%h want=%h", obs[1], want); end
        for (int i = 0; i < 170; i++) begin
            step(1, 1'b1, 1'b1);
            want = sb.pop_front(); total++;
            if (obs[1] !== want) begin bad++; $display("FAIL tiny_run cyc=%0d got=%h want=%h", i, obs[1], want); end
            if (t_eol === 1'b1) begin
                if (last_eol >= 0) begin
                    total++;
                    if (i - last_eol != 7) begin bad++; $display("FAIL tiny_eol_period got=%0d want=7", i - last_eol); end
                end
                last_eol = i;
            end
            if (t_sof === 1'b1) begin
                if (last_sof >= 0) begin
                    total++;
                    if (i - last_sof != 42) begin bad++; $display("FAIL tiny_frame_len got=%0d want=42", i - last_sof); end
                    total++;
                    if (n_sof <= 4 && int'(t_fc) != fc_seq[n_sof-1]) begin
                        bad++; $display("FAIL tiny_fc frame=%0d got=%0d want=%0d", n_sof, t_fc, fc_seq[n_sof-1]);
                    end
                end
                last_sof = i; n_sof++;
            end
        end
        total++;
        if (n_sof != 5) begin bad++; $display("FAIL tiny_sof_count got=%0d want=5", n_sof); end
    endtask

    task automatic test_en_at_release();
        logic [54:0] want;
        step(1, 1'b0, 1'b0); void'(sb.pop_front());
        for (int i = 0; i < 5; i++) begin
            step(1, 1'b1, 1'b0);
            want = sb.pop_front(); total++;
            if (obs[1] !== want || {t_stb, t_sof, t_eol} !== 3'b000) begin
                bad++; $display("FAIL idle_release cyc=%0d got=%h want=%h", i, obs[1], want);
            end
        end
        step(1, 1'b1, 1'b1);
        want = sb.pop_front(); total++;
        if (obs[1] !== want || {t_stb, t_sof, t_eol, t_act} !== 4'b1111) begin
            bad++; $display("FAIL en_rise got=%b want=1111", {t_stb, t_sof, t_eol, t_act});
        end
    endtask

    task automatic test_div2_pol();
        logic [54:0] want;
        int last_stb = -1, last_sof = -1, hs_hits = 0;
        step(2, 1'b0, 1'b1); void'(sb.pop_front());
        step(2, 1'b0, 1'b1);
        want = sb.pop_front(); total++;
        if (obs[2] !== want || {a_hs, a_vs, a_sync} !== 3'b001) begin
            bad++; $display("FAIL pol_idle got=%b want=001", {a_hs, a_vs, a_sync});
        end
        for (int i = 0; i < 174; i++) begin
            step(2, 1'b1, 1'b1);
            want = sb.pop_front(); total++;
            if (obs[2] !== want) begin bad++; $display("FAIL div2_run cyc=%0d got=%h want=%h", i, obs[2], want); end
            if (a_stb === 1'b1) begin
                if (last_stb >= 0) begin
                    total++;
                    if (i - last_stb != 2) begin bad++; $display("FAIL div2_stb_period got=%0d want=2", i - last_stb); end
                end
                last_stb = i;
            end
            if (a_sof === 1'b1) begin
                if (last_sof >= 0) begin
                    total++;
                    if (i - last_sof != 84) begin bad++; $display("FAIL div2_frame_len got=%0d want=84", i - last_sof); end
                end
                last_sof = i;
            end
            if (a_hs === 1'b1) begin
                hs_hits++;
                total++;
                if (a_x !== 4'd5 || a_sync !== 1'b0) begin
                    bad++; $display("FAIL pol_hs_pos got x=%0d sync=%b want x=5 sync=0", a_x, a_sync);
                end
            end
        end
        total++;
        if (hs_hits < 24) begin bad++; $display("FAIL pol_hs_seen got=%0d want>=24", hs_hits); end
    endtask

    task automatic test_random_en();
        logic [54:0] want;
        bit e;
        for (int i = 0; i < 400; i++) begin
            e = ($urandom_range(0, 3) != 0);
            step(2, 1'b1, e);
            want = sb.pop_front(); total++;
            if (obs[2] !== want) begin bad++; $display("FAIL random_en cyc=%0d got=%h want=%h", i, obs[2], want); end
        end
    endtask

    initial begin
        cfg[0] = '{ha: 640, hf: 16, hsw: 96, hb: 48, va: 480, vf: 10, vsw: 2, vb: 33, div: 1, fcw: 16, pol: 1'b0};
        cfg[1] = '{ha: 4, hf: 1, hsw: 1, hb: 1, va: 3, vf: 1, vsw: 1, vb: 1, div: 1, fcw: 2, pol: 1'b0};
        cfg[2] = '{ha: 4, hf: 1, hsw: 1, hb: 1, va: 3, vf: 1, vsw: 1, vb: 1, div: 2, fcw: 16, pol: 1'b1};
        @(posedge clk);
        #1;
        test_reset();
        test_first_line();
        test_pause();
        test_reset_mid();
        test_tiny_frames();
        test_en_at_release();
        test_div2_pol();
        test_random_en();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
